// File: rtl/dmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_arbiter_if
// Request/response bundle for one requester of the shared data memory.
//   req    : access request, level, held until granted
//   addr   : byte address
//   wen    : 1 = write, 0 = read
//   byt    : 1 = byte access, 0 = word access
//   wdata  : write data (byte data in [7:0])
//   gnt    : request accepted this cycle
//   rvalid : read data valid, one cycle after a granted read
//   rdata  : read data, meaningful only while rvalid is high
// master : requester side, slave : arbiter side.
// ----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int AW = 14
) ();
  logic          req;
  logic [AW-1:0] addr;
  logic          wen;
  logic          byt;
  logic [15:0]   wdata;
  logic          gnt;
  logic          rvalid;
  logic [15:0]   rdata;

  modport master (
    output req, addr, wen, byt, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, wen, byt, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data memory (registered one-cycle read) between
// port 0 (CPU data port) and port 1 (debug/loader port). Port 0 normally
// wins contention; after MAX_CONSEC consecutive port-0 wins while port 1
// waits, port 1 is granted. Writes are byte-lane steered, read data is
// routed back to the owner one cycle after the grant.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   m0, m1          : requester bundles (slave side of dmem_arbiter_if)
//   mem_addr_o      : memory byte address
//   mem_wen_o       : memory write enable
//   mem_byt_o       : memory byte access
//   mem_wdata_o     : memory write data
//   mem_rdata_i     : memory read data (valid one cycle after address)
// ----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW         = 14,
  parameter int MAX_CONSEC = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave m0,
  dmem_arbiter_if.slave m1,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_wen_o,
  output logic          mem_byt_o,
  output logic [15:0]   mem_wdata_o,
  input  logic [15:0]   mem_rdata_i
);

  localparam logic [3:0] CNT_MAX = 4'(MAX_CONSEC);

  logic [3:0]  cnt_q, cnt_d;
  logic        rd_vld_q, rd_vld_d;
  logic        owner_q, owner_d;
  logic        byt_q, byt_d;
  logic        lsb_q, lsb_d;
  logic        gnt0, gnt1;
  logic [15:0] wdata_sel;
  logic [15:0] rdata_steer;

  // Arbitration depends only on requests and the registered counter, so
  // there is no path from mem_rdata_i to either grant.
  always_comb begin
    gnt1 = m1.req && (!m0.req || (cnt_q == CNT_MAX));
    gnt0 = m0.req && !gnt1;
  end

  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;

  // Counts port-0 wins while port 1 is waiting; any port-1 grant or a cycle
  // without a port-1 request ends the starvation window.
  always_comb begin
    cnt_d = cnt_q;
    if (!m1.req || gnt1) begin
      cnt_d = '0;
    end else if (gnt0 && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Memory drive: port 1 only when granted, otherwise port 0 fields
  // (this also covers the idle case).
  always_comb begin
    if (gnt1) begin
      mem_addr_o = m1.addr;
      mem_byt_o  = m1.byt;
      wdata_sel  = m1.wdata;
    end else begin
      mem_addr_o = m0.addr;
      mem_byt_o  = m0.byt;
      wdata_sel  = m0.wdata;
    end
  end

  // Write enable is held off during reset even though grants still follow
  // the requests.
  assign mem_wen_o   = rst_n && ((gnt0 && m0.wen) || (gnt1 && m1.wen));
  // Byte writes replicate the byte on both lanes; the memory picks the lane
  // from addr[0].
  assign mem_wdata_o = mem_byt_o ? {wdata_sel[7:0], wdata_sel[7:0]} : wdata_sel;

  // Capture read context on a granted read; hold it otherwise.
  always_comb begin
    rd_vld_d = (gnt0 && !m0.wen) || (gnt1 && !m1.wen);
    owner_d  = owner_q;
    byt_d    = byt_q;
    lsb_d    = lsb_q;
    if (rd_vld_d) begin
      owner_d = gnt1;
      byt_d   = mem_byt_o;
      lsb_d   = mem_addr_o[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      rd_vld_q <= 1'b0;
      owner_q  <= 1'b0;
      byt_q    <= 1'b0;
      lsb_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rd_vld_q <= rd_vld_d;
      owner_q  <= owner_d;
      byt_q    <= byt_d;
      lsb_q    <= lsb_d;
    end
  end

  // Word reads pass through untouched (misaligned words included); byte
  // reads select the lane recorded at grant time and zero-extend.
  always_comb begin
    if (!byt_q) begin
      rdata_steer = mem_rdata_i;
    end else if (lsb_q) begin
      rdata_steer = {8'h00, mem_rdata_i[15:8]};
    end else begin
      rdata_steer = {8'h00, mem_rdata_i[7:0]};
    end
  end

  assign m0.rdata  = rdata_steer;
  assign m1.rdata  = rdata_steer;
  assign m0.rvalid = rd_vld_q && !owner_q;
  assign m1.rvalid = rd_vld_q && owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
// Scoreboard bench for dmem_arbiter. A driver presents transactions from two
// per-port stimulus queues, predicts each cycle's grant and memory drive from
// the fairness rule, and predicts read data from a byte-addressed reference
// memory. A monitor pops those predictions and compares them against the DUT.
// A behavioural memory with a registered read sits on the mem_* side.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;
  localparam int AW         = 14;
  localparam int MAX_CONSEC = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW)) m0_if ();
  dmem_arbiter_if #(.AW(AW)) m1_if ();

  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic          mem_byt;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;

  dmem_arbiter #(.AW(AW), .MAX_CONSEC(MAX_CONSEC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0         (m0_if),
    .m1         (m1_if),
    .mem_addr_o (mem_addr),
    .mem_wen_o  (mem_wen),
    .mem_byt_o  (mem_byt),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  // Behavioural single-port memory, 8K x 16, lane chosen by addr[0].
  logic [15:0] mem_arr [0:(1<<(AW-1))-1];
  always @(posedge clk) begin
    if (mem_wen) begin
      if (mem_byt) begin
        if (mem_addr[0]) mem_arr[mem_addr[AW-1:1]][15:8] <= mem_wdata[15:8];
        else             mem_arr[mem_addr[AW-1:1]][7:0]  <= mem_wdata[7:0];
      end else begin
        mem_arr[mem_addr[AW-1:1]] <= mem_wdata;
      end
    end
    mem_rdata <= mem_arr[mem_addr[AW-1:1]];
  end

  typedef struct {
    logic          idle;
    logic [AW-1:0] addr;
    logic          wen;
    logic          byt;
    logic [15:0]   wdata;
  } txn_t;

  typedef struct {
    logic          g0;
    logic          g1;
    logic          wen;
    logic [AW-1:0] addr;
    logic          byt;
    logic [15:0]   wdata;
  } cyc_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } rd_t;

  txn_t stim0[$];
  txn_t stim1[$];
  cyc_t exp_q[$];
  rd_t  rdq0[$];
  rd_t  rdq1[$];

  logic [7:0] ref_mem [0:(1<<AW)-1];
  int  p1_passed = 0;   // consecutive cycles port 1 lost to port 0
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  drv_en = 1'b0;
  bit  sb_on  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic txn_t mk(input logic idle, input int addr, input logic wen,
                              input logic byt, input logic [15:0] wdata);
    txn_t t;
    t.idle  = idle;
    t.addr  = AW'(addr);
    t.wen   = wen;
    t.byt   = byt;
    t.wdata = wdata;
    return t;
  endfunction

  function automatic txn_t rnd_txn(input int idle_pct);
    return mk(($urandom_range(0, 99) < idle_pct), $urandom_range(0, 63),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
  endfunction

  function automatic logic [15:0] ref_read(input txn_t t);
    int a  = int'(t.addr);
    int lo = a & ~1;
    if (t.byt) return {8'h00, ref_mem[a]};
    return {ref_mem[lo + 1], ref_mem[lo]};
  endfunction

  function automatic void ref_write(input txn_t t);
    int a  = int'(t.addr);
    int lo = a & ~1;
    if (t.byt) begin
      ref_mem[a] = t.wdata[7:0];
    end else begin
      ref_mem[lo]     = t.wdata[7:0];
      ref_mem[lo + 1] = t.wdata[15:8];
    end
  endfunction

  function automatic void ref_access(input int port, input txn_t t);
    rd_t r;
    if (t.wen) begin
      ref_write(t);
    end else begin
      r.cyc  = cyc + 1;
      r.data = ref_read(t);
      if (port == 0) rdq0.push_back(r);
      else           rdq1.push_back(r);
    end
  endfunction

  // Driver + reference model
  initial begin : driver
    txn_t t0, t1;
    logic r0, r1;
    int   win;
    cyc_t e;
    forever begin
      @(negedge clk);
      if (drv_en) begin
        r0 = 1'b0;
        r1 = 1'b0;
        t0 = mk(1'b1, 0, 1'b0, 1'b0, 16'h0);
        t1 = t0;
        if (stim0.size() > 0) begin
          t0 = stim0[0];
          if (t0.idle) void'(stim0.pop_front());
          else r0 = 1'b1;
        end
        if (stim1.size() > 0) begin
          t1 = stim1[0];
          if (t1.idle) void'(stim1.pop_front());
          else r1 = 1'b1;
        end
        m0_if.req   = r0;
        m0_if.addr  = r0 ? t0.addr : AW'($urandom);
        m0_if.wen   = t0.wen;
        m0_if.byt   = t0.byt;
        m0_if.wdata = t0.wdata;
        m1_if.req   = r1;
        m1_if.addr  = r1 ? t1.addr : AW'($urandom);
        m1_if.wen   = t1.wen;
        m1_if.byt   = t1.byt;
        m1_if.wdata = t1.wdata;

        // Port 0 has priority, but port 1 may be passed over at most
        // MAX_CONSEC times in a row.
        if (r0 && r1)  win = (p1_passed == MAX_CONSEC) ? 1 : 0;
        else if (r1)   win = 1;
        else if (r0)   win = 0;
        else           win = -1;
        if (r1 && win == 0) p1_passed++;
        else                p1_passed = 0;

        e.g0    = (win == 0);
        e.g1    = (win == 1);
        e.addr  = (win == 1) ? t1.addr : m0_if.addr;
        e.wen   = (win == 0) ? t0.wen : ((win == 1) ? t1.wen : 1'b0);
        e.byt   = (win == 1) ? t1.byt : t0.byt;
        e.wdata = (win == 1) ? t1.wdata : t0.wdata;
        if (e.byt) e.wdata = {e.wdata[7:0], e.wdata[7:0]};
        exp_q.push_back(e);

        if (win == 0) begin
          ref_access(0, t0);
          void'(stim0.pop_front());
        end else if (win == 1) begin
          ref_access(1, t1);
          void'(stim1.pop_front());
        end
      end
    end
  end

  task automatic check_rd(input int port);
    logic        rv;
    logic [15:0] rd;
    rd_t         r;
    bit          have;
    rv   = (port == 0) ? m0_if.rvalid : m1_if.rvalid;
    rd   = (port == 0) ? m0_if.rdata  : m1_if.rdata;
    have = (port == 0) ? (rdq0.size() > 0) : (rdq1.size() > 0);
    if (have) r = (port == 0) ? rdq0[0] : rdq1[0];
    if (rv) begin
      checks++;
      if (!have || r.cyc != cyc) begin
        errors++;
        $display("FAIL rvalid_p%0d_unexpected: got rvalid=1 expected 0 (cycle %0d)", port, cyc);
      end else begin
        if (port == 0) void'(rdq0.pop_front());
        else           void'(rdq1.pop_front());
        $display("read port%0d cycle %0d data %h", port, cyc, rd);
        chk($sformatf("rdata_p%0d", port), 32'(rd), 32'(r.data));
      end
    end else if (have && r.cyc <= cyc) begin
      checks++;
      errors++;
      $display("FAIL rvalid_p%0d_missing: got rvalid=0 expected 1 (cycle %0d)", port, cyc);
      if (port == 0) void'(rdq0.pop_front());
      else           void'(rdq1.pop_front());
    end
  endtask

  // Monitor: compares DUT outputs against the queued predictions.
  initial begin : monitor
    cyc_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("m0_gnt",   32'(m0_if.gnt), 32'(e.g0));
        chk("m1_gnt",   32'(m1_if.gnt), 32'(e.g1));
        chk("one_gnt",  32'(m0_if.gnt && m1_if.gnt), 32'd0);
        chk("mem_wen",  32'(mem_wen),   32'(e.wen));
        chk("mem_addr", 32'(mem_addr),  32'(e.addr));
        if (e.g0 || e.g1) chk("mem_byt", 32'(mem_byt), 32'(e.byt));
        if (e.wen)        chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
      end
      if (sb_on) begin
        check_rd(0);
        check_rd(1);
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while ((stim0.size() + stim1.size() + rdq0.size() + rdq1.size()) != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 4000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               stim0.size() + stim1.size() + rdq0.size() + rdq1.size());
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin : main
    rst_n       = 1'b0;
    m0_if.req   = 1'b0;  m1_if.req   = 1'b0;
    m0_if.addr  = '0;    m1_if.addr  = '0;
    m0_if.wen   = 1'b0;  m1_if.wen   = 1'b0;
    m0_if.byt   = 1'b0;  m1_if.byt   = 1'b0;
    m0_if.wdata = '0;    m1_if.wdata = '0;

    // Reset state: no rvalid, and a write request during reset is granted
    // but never reaches the memory.
    repeat (2) @(negedge clk);
    #2;
    chk("rst_m0_rvalid", 32'(m0_if.rvalid), 32'd0);
    chk("rst_m1_rvalid", 32'(m1_if.rvalid), 32'd0);
    @(negedge clk);
    m0_if.req = 1'b1; m0_if.wen = 1'b1; m0_if.addr = 14'h0010; m0_if.wdata = 16'h1111;
    #2;
    chk("rst_m0_gnt",  32'(m0_if.gnt), 32'd1);
    chk("rst_mem_wen", 32'(mem_wen),   32'd0);
    @(negedge clk);
    m0_if.req = 1'b0; m0_if.wen = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    drv_en = 1'b1;
    sb_on  = 1'b1;

    // Preload the working window so every later read has defined data.
    for (int a = 0; a < 64; a += 2) stim0.push_back(mk(1'b0, a, 1'b1, 1'b0, 16'($urandom)));
    wait_drain();

    // Port 0 word write then read.
    stim0.push_back(mk(1'b0, 'h10, 1'b1, 1'b0, 16'hBEEF));
    stim0.push_back(mk(1'b0, 'h10, 1'b0, 1'b0, 16'h0));
    wait_drain();

    // Port 1 byte lanes.
    stim1.push_back(mk(1'b0, 'h20, 1'b1, 1'b0, 16'h1234));
    stim1.push_back(mk(1'b0, 'h21, 1'b1, 1'b1, 16'h00AB));
    stim1.push_back(mk(1'b0, 'h20, 1'b0, 1'b1, 16'h0));
    stim1.push_back(mk(1'b0, 'h21, 1'b0, 1'b1, 16'h0));
    stim1.push_back(mk(1'b0, 'h20, 1'b0, 1'b0, 16'h0));
    wait_drain();

    // Pipelined alternating reads m0 @2 / m1 @4.
    stim0.push_back(mk(1'b0, 2, 1'b1, 1'b0, 16'h5A5A));
    stim1.push_back(mk(1'b0, 4, 1'b1, 1'b0, 16'hC3C3));
    wait_drain();
    for (int i = 0; i < 4; i++) begin
      stim0.push_back(mk(1'b0, 2, 1'b0, 1'b0, 16'h0));
      stim0.push_back(mk(1'b1, 0, 1'b0, 1'b0, 16'h0));
      stim1.push_back(mk(1'b1, 0, 1'b0, 1'b0, 16'h0));
      stim1.push_back(mk(1'b0, 4, 1'b0, 1'b0, 16'h0));
    end
    wait_drain();

    // Sustained contention: both ports always requesting.
    for (int i = 0; i < 15; i++) begin
      stim0.push_back(rnd_txn(0));
      stim1.push_back(rnd_txn(0));
    end
    wait_drain();

    // Idle, then re-read to confirm nothing changed.
    for (int i = 0; i < 10; i++) stim0.push_back(mk(1'b1, 0, 1'b0, 1'b0, 16'h0));
    stim0.push_back(mk(1'b0, 'h10, 1'b0, 1'b0, 16'h0));
    stim0.push_back(mk(1'b0, 'h20, 1'b0, 1'b0, 16'h0));
    wait_drain();

    // Random mixed traffic.
    for (int i = 0; i < 150; i++) begin
      stim0.push_back(rnd_txn(30));
      stim1.push_back(rnd_txn(30));
    end
    wait_drain();

    // Reset in the cycle after a port-0 read grant, with the counter at its
    // limit so that port 1 would otherwise win next.
    drv_en = 1'b0;
    @(negedge clk);
    #3;
    sb_on = 1'b0;
    @(negedge clk);
    m0_if.req = 1'b1; m0_if.wen = 1'b0; m0_if.byt = 1'b0; m0_if.addr = 14'h0010;
    m1_if.req = 1'b1; m1_if.wen = 1'b0; m1_if.byt = 1'b0; m1_if.addr = 14'h0020;
    for (int i = 0; i < MAX_CONSEC; i++) begin
      #2;
      chk("pre_rst_m0_gnt", 32'(m0_if.gnt), 32'd1);
      @(posedge clk);
      if (i < MAX_CONSEC - 1) @(negedge clk);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("midrd_m0_rvalid", 32'(m0_if.rvalid), 32'd0);
    chk("midrd_m1_rvalid", 32'(m1_if.rvalid), 32'd0);
    @(negedge clk);
    m0_if.wen = 1'b1; m0_if.wdata = 16'hDEAD;
    #2;
    chk("inrst_mem_wen", 32'(mem_wen), 32'd0);
    @(posedge clk);
    #1;
    chk("inrst_m0_rvalid", 32'(m0_if.rvalid), 32'd0);
    @(negedge clk);
    m0_if.wen = 1'b0;
    rst_n = 1'b1;
    #2;
    chk("post_rst_m0_gnt", 32'(m0_if.gnt), 32'd1);
    chk("post_rst_m1_gnt", 32'(m1_if.gnt), 32'd0);
    @(negedge clk);
    m0_if.req = 1'b0; m1_if.req = 1'b0;
    repeat (3) @(posedge clk);

    // Back to scoreboard mode: the write attempted during reset must not
    // have landed.
    p1_passed = 0;
    sb_on  = 1'b1;
    drv_en = 1'b1;
    stim0.push_back(mk(1'b0, 'h10, 1'b0, 1'b0, 16'h0));
    stim1.push_back(mk(1'b0, 'h20, 1'b0, 1'b0, 16'h0));
    wait_drain();

    chk("rdq0_empty", 32'(rdq0.size()), 32'd0);
    chk("rdq1_empty", 32'(rdq1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (CPU data port) and port 1 (debug/loader port, e.g. UART monitor).
- Performs per-cycle arbitration, byte-lane steering for writes, and read-return routing that accounts for the memory's registered one-cycle read latency.
- Sits between the CPU/debug logic and the data memory and is the only driver of the memory's addr/wen/byt/data_in.

Parameters:
- AW, 14, byte-address width (16 KiB data space, 8K x 16-bit words).
- MAX_CONSEC, 4, max consecutive port-0 grants while port 1 waits; range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  port 0 access request, level, held until granted
- m0_addr  in  AW  port 0 byte address
- m0_wen  in  1  port 0 write (1) / read (0)
- m0_byt  in  1  port 0 byte access (1) / word access (0)
- m0_wdata  in  16  port 0 write data; byte data in [7:0]
- m0_gnt  out  1  port 0 request accepted this cycle (combinational)
- m0_rvalid  out  1  port 0 read data valid (registered)
- m0_rdata  out  16  port 0 read data
- m1_req, m1_addr, m1_wen, m1_byt, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
- mem_addr  out  AW  to memory addr
- mem_wen  out  1  to memory wen
- mem_byt  out  1  to memory byt
- mem_wdata  out  16  to memory data_in
- mem_rdata  in  16  from memory data_out (valid one cycle after address)

Behaviour:
- Transfer: occurs in a cycle where mX_req && mX_gnt. At most one gnt high per cycle. gnt only when the matching req is high.
- Arbitration, combinational from req and registered state:
  - only one req -> grant it
  - both req -> grant port 0, unless cnt == MAX_CONSEC, in which case grant port 1
- cnt (4-bit), state-machine view:
  - +1 on each cycle port 0 is granted while m1_req is high, saturating at MAX_CONSEC
  - cleared on any port 1 grant, or on any cycle m1_req is low
  - Guarantees port 1 waits at most MAX_CONSEC+1 cycles.
- Memory drive:
  - mem_addr/mem_byt take the granted port's fields.
  - mem_wen = granted port's wen; 0 when nothing is granted.
  - mem_addr = m0_addr when idle.
- Write steering: mem_wdata = byt ? {wdata[7:0], wdata[7:0]} : wdata. The memory selects the lane via addr[0].
- Read return:
  - On a granted read, register the owner (0/1), byt, and addr[0].
  - Next cycle, pulse the owner's rvalid for exactly 1 cycle.
  - rdata:
    - word read -> mem_rdata
    - byte read, addr[0]=0 -> {8'h00, mem_rdata[7:0]}
    - byte read, addr[0]=1 -> {8'h00, mem_rdata[15:8]}
  - Word access with addr[0]=1 is passed through unmodified; word alignment is the requester's responsibility.
  - Both mX_rdata are driven from the same steered value; each is valid only with its own rvalid.
- Writes produce no rvalid.
- Back-to-back accesses are fully pipelined: a new grant may coincide with the rvalid of the previous read, at 1 access per cycle.
- Reset (rst_n low, async):
  - m0_rvalid = m1_rvalid = 0, cnt = 0, owner = 0, registered byt/lsb = 0.
  - A read granted in the cycle before reset returns no rvalid.
  - gnt and mem_* follow the combinational rules, except mem_wen, which is forced to 0 while rst_n is low.
- Implementation constraint: no combinational path from mem_rdata to any gnt.

Test Plan:
- Single port 0 word write then read: write addr 14'h0010 data 16'hBEEF, then read addr 14'h0010 -> m0_gnt high both cycles; m0_rvalid high exactly 1 cycle after the read grant, m0_rdata = 16'hBEEF; m1_rvalid stays 0.
- Byte lanes from port 1: word write 16'h1234 at 14'h0020, byte write 8'hAB at 14'h0021, then byte reads 14'h0020 and 14'h0021 -> mem_wdata = 16'hABAB during the byte write; reads return 16'h0034 and 16'h00AB; word read 14'h0020 returns 16'hAB34.
- Contention, MAX_CONSEC=4: m0_req and m1_req held high continuously -> grant pattern 0,0,0,0,1,0,0,0,0,1,...; never two gnts in one cycle.
- Pipelined mixed reads: alternating grants m0 read @2, m1 read @4 -> each rvalid goes to the correct port one cycle after its grant, with the correct data, and no lost or duplicated rvalid.
- Reset mid-read: assert rst_n low in the cycle after a m0 read grant -> m0_rvalid stays 0; after release, cnt = 0, so port 0 wins first contention.
- Idle: no req for 10 cycles -> mem_wen = 0, gnts = 0, rvalids = 0, and memory contents are unchanged on re-read.
